demux_steer: RTL and testbench
==============================

// Module: demux_steer
// PURPOSE
//  Registered 1-to-NUM_OUT demultiplexer with valid/ready handshake.
//  Steers one input word to exactly one of NUM_OUT destinations, chosen by IN_SEL.
//  It is the fan-out counterpart of the datapath 2x1 selector.
//  Use: route write data from the core to the data memory or to MMIO sinks.
//  Each destination has its own 1-entry holding register, so a stalled sink
//  blocks only traffic addressed to that sink.
// PARAMETERS
//  WIDTH    32  data word width in bits
//  NUM_OUT  3   number of destinations (2..8)
//  SEL_W    3   width of IN_SEL; must satisfy 2**SEL_W >= NUM_OUT
// PORTS
//  CLK        in   1               rising-edge clock
//  RST        in   1               synchronous reset, active-high
//  IN_VALID   in   1               input word present
//  IN_READY   out  1               block accepts the input word this cycle
//  IN_DATA    in   WIDTH           input word
//  IN_SEL     in   SEL_W           destination index
//  OUT_VALID  out  NUM_OUT         per-destination word present
//  OUT_READY  in   NUM_OUT         per-destination sink accepts
//  OUT_DATA   out  NUM_OUT*WIDTH   destination k on bits [k*WIDTH +: WIDTH]
//  SEL_ERR    out  1               1-cycle pulse: word with IN_SEL >= NUM_OUT dropped
//  XFER_CNT   out  16              count of accepted words, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Clock and reset
//      One clock domain: CLK.
//      RST is synchronous and active-high.
//      Reset takes priority over all other inputs.
//  - Reset values
//      OUT_VALID = 0, OUT_DATA = 0, SEL_ERR = 0, XFER_CNT = 0.
//  - Per-destination FSM k, two states:
//      EMPTY (OUT_VALID[k]=0) / FULL (OUT_VALID[k]=1).
//  - Definitions
//      acc  = IN_VALID & IN_READY
//      ld_k = acc & (IN_SEL==k)
//      dr_k = OUT_VALID[k] & OUT_READY[k]
//  - Transitions
//      EMPTY, ld_k     -> FULL; OUT_DATA[k] <= IN_DATA.
//      FULL,  dr_k, !ld_k -> EMPTY; OUT_DATA[k] holds its last value.
//      FULL,  dr_k, ld_k  -> FULL; new word loaded (back-to-back, no bubble).
//      FULL,  !dr_k    -> FULL; data held stable.
//  - IN_READY (combinational, no dependence on IN_VALID)
//      IN_SEL <  NUM_OUT: IN_READY = !OUT_VALID[IN_SEL] | OUT_READY[IN_SEL].
//      IN_SEL >= NUM_OUT: IN_READY = 1; the word is consumed and dropped.
//  - SEL_ERR
//      Asserted for exactly one cycle after each dropped word.
//      No output state changes on a dropped word.
//  - Latency
//      Word accepted at edge n appears on OUT_VALID/OUT_DATA after edge n.
//      Throughput: 1 word per cycle per destination.
//  - XFER_CNT
//      +1 on every acc with a valid IN_SEL; dropped words are not counted.
//      Wraps modulo 2**16.
//  - Ordering
//      Per-destination order is preserved.
//      Words sent to different destinations may drain in any relative order.
//  - OUT_READY[k] while OUT_VALID[k]=0: ignored.
//  - RST mid-transfer: all held words are discarded; IN_READY follows the rule above.
//  - OUT_DATA[k] changes only on ld_k or on reset.
// TESTING
//  1. Reset: RST=1 for 2 cycles
//       -> OUT_VALID=0, OUT_DATA=0, XFER_CNT=0, SEL_ERR=0.
//  2. Single word: IN_SEL=1, IN_DATA=32'hDEADBEEF, OUT_READY=3'b111
//       -> OUT_VALID=3'b010 for 1 cycle, OUT_DATA[1]=32'hDEADBEEF, XFER_CNT=1.
//  3. Backpressure: OUT_READY[0]=0, send 32'h11 then 32'h22 to dest 0
//       -> 2nd word sees IN_READY=0; 32'h11 held stable.
//       -> Raise OUT_READY[0]: 32'h22 loads the same cycle 32'h11 drains.
//  4. Isolation: dest 2 stalled FULL; send 4 words to dest 0 with OUT_READY[0]=1
//       -> IN_READY=1 every cycle; 4 words delivered in order; OUT_DATA[2] unchanged.
//  5. Bad select: IN_SEL=3'd5, IN_VALID=1 for 1 cycle
//       -> IN_READY=1, SEL_ERR pulses once, OUT_VALID and XFER_CNT unchanged.
//  6. Wrap + reset: preload XFER_CNT=16'hFFFF via 65535 transfers, send one more
//       -> XFER_CNT=0.
//       -> Assert RST while dest 1 is FULL: OUT_VALID[1]=0 on the next cycle.

Source files
------------

// File: rtl/demux_steer.sv
// Registered 1-to-NUM_OUT demultiplexer with valid/ready handshake.
// Every destination has its own 1-entry holding slot, so a stalled sink blocks only its own traffic.

module demux_steer_slot #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ld,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= EMPTY;
            out_data <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (ld) begin
                        state    <= FULL;
                        out_data <= in_data;
                    end
                end
                FULL: begin
                    // ld can only occur alongside a drain here, giving a bubble-free reload
                    if (ld)
                        out_data <= in_data;
                    else if (out_ready)
                        state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign out_valid = (state == FULL);
endmodule

module demux_steer #(
    parameter int WIDTH   = 32,
    parameter int NUM_OUT = 3,
    parameter int SEL_W   = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [WIDTH-1:0]         IN_DATA,
    input  logic [SEL_W-1:0]         IN_SEL,
    output logic [NUM_OUT-1:0]       OUT_VALID,
    input  logic [NUM_OUT-1:0]       OUT_READY,
    output logic [NUM_OUT*WIDTH-1:0] OUT_DATA,
    output logic                     SEL_ERR,
    output logic [15:0]              XFER_CNT
);
    logic               sel_ok;
    logic               acc;
    logic [NUM_OUT-1:0] ld;

    // Out-of-range selects are always accepted so the bad word is consumed and dropped
    always_comb begin
        IN_READY = 1'b1;
        sel_ok   = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (IN_SEL == SEL_W'(k)) begin
                sel_ok   = 1'b1;
                IN_READY = !OUT_VALID[k] | OUT_READY[k];
            end
        end
    end

    assign acc = IN_VALID & IN_READY;

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        assign ld[k] = acc & (IN_SEL == SEL_W'(k));

        demux_steer_slot #(.WIDTH(WIDTH)) u_slot (
            .CLK       (CLK),
            .RST       (RST),
            .ld        (ld[k]),
            .in_data   (IN_DATA),
            .out_ready (OUT_READY[k]),
            .out_valid (OUT_VALID[k]),
            .out_data  (OUT_DATA[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            SEL_ERR  <= 1'b0;
            XFER_CNT <= '0;
        end else begin
            SEL_ERR <= acc & !sel_ok;
            if (acc & sel_ok)
                XFER_CNT <= XFER_CNT + 16'd1;
        end
    end
endmodule

// File: tb/tb_demux_steer.sv
// Self-checking bench for demux_steer: vector table, hand-written corner sequences,
// and randomized traffic checked against a per-destination holding model.

module tb_demux_steer;
    localparam int W = 32;
    localparam int N = 3;
    localparam int S = 3;

    logic           CLK = 1'b0;
    logic           RST;
    logic           IN_VALID;
    logic           IN_READY;
    logic [W-1:0]   IN_DATA;
    logic [S-1:0]   IN_SEL;
    logic [N-1:0]   OUT_VALID;
    logic [N-1:0]   OUT_READY;
    logic [N*W-1:0] OUT_DATA;
    logic           SEL_ERR;
    logic [15:0]    XFER_CNT;

    int passed = 0;
    int total  = 0;

    demux_steer #(.WIDTH(W), .NUM_OUT(N), .SEL_W(S)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_DATA(IN_DATA), .IN_SEL(IN_SEL), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .SEL_ERR(SEL_ERR),
        .XFER_CNT(XFER_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         rst;
        logic         iv;
        logic [S-1:0] sel;
        logic [W-1:0] d;
        logic [N-1:0] ordy;
        logic         x_irdy;
        logic [N-1:0] x_ov;
        logic [N*W-1:0] x_od;
        logic         x_err;
        logic [15:0]  x_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic drive(input logic rst, input logic iv, input logic [S-1:0] sel,
                         input logic [W-1:0] d, input logic [N-1:0] ordy);
        RST = rst; IN_VALID = iv; IN_SEL = sel; IN_DATA = d; OUT_READY = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // behavioural model state
    logic         mv [N];
    logic [W-1:0] md [N];
    int           mcnt;
    logic         merr;

    function automatic logic [N*W-1:0] model_od();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = md[k];
        return r;
    endfunction

    function automatic logic [N-1:0] model_ov();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = mv[k];
        return r;
    endfunction

    vec_t tbl [10];

    initial begin
        logic [N*W-1:0] od0;
        logic [W-1:0]   hold2;

        //             rst  iv   sel   data          ordy    irdy ov      od                              err  cnt
        tbl[0] = '{1'b1, 1'b0, 3'd5, 32'h0,        3'b000, 1'b1, 3'b000, {32'h0, 32'h0,        32'h0},  1'b0, 16'd0};
        tbl[1] = '{1'b1, 1'b0, 3'd5, 32'h0,        3'b000, 1'b1, 3'b000, {32'h0, 32'h0,        32'h0},  1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 3'd1, 32'hDEADBEEF, 3'b111, 1'b1, 3'b010, {32'h0, 32'hDEADBEEF, 32'h0},  1'b0, 16'd1};
        tbl[3] = '{1'b0, 1'b0, 3'd1, 32'h0,        3'b111, 1'b1, 3'b000, {32'h0, 32'hDEADBEEF, 32'h0},  1'b0, 16'd1};
        tbl[4] = '{1'b0, 1'b1, 3'd5, 32'h1234,     3'b111, 1'b1, 3'b000, {32'h0, 32'hDEADBEEF, 32'h0},  1'b1, 16'd1};
        tbl[5] = '{1'b0, 1'b0, 3'd0, 32'h0,        3'b111, 1'b1, 3'b000, {32'h0, 32'hDEADBEEF, 32'h0},  1'b0, 16'd1};
        tbl[6] = '{1'b0, 1'b1, 3'd0, 32'h11,       3'b110, 1'b1, 3'b001, {32'h0, 32'hDEADBEEF, 32'h11}, 1'b0, 16'd2};
        tbl[7] = '{1'b0, 1'b1, 3'd0, 32'h22,       3'b110, 1'b0, 3'b001, {32'h0, 32'hDEADBEEF, 32'h11}, 1'b0, 16'd2};
        tbl[8] = '{1'b0, 1'b1, 3'd0, 32'h22,       3'b111, 1'b1, 3'b001, {32'h0, 32'hDEADBEEF, 32'h22}, 1'b0, 16'd3};
        tbl[9] = '{1'b0, 1'b0, 3'd0, 32'h0,        3'b111, 1'b1, 3'b000, {32'h0, 32'hDEADBEEF, 32'h22}, 1'b0, 16'd3};

        drive(1'b1, 1'b0, 3'd5, 32'h0, 3'b000);
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].ordy);
            chk($sformatf("tbl%0d in_ready", i), {95'b0, IN_READY}, {95'b0, tbl[i].x_irdy});
            tick();
            chk($sformatf("tbl%0d out_valid", i), {93'b0, OUT_VALID}, {93'b0, tbl[i].x_ov});
            chk($sformatf("tbl%0d out_data", i), OUT_DATA, tbl[i].x_od);
            chk($sformatf("tbl%0d sel_err", i), {95'b0, SEL_ERR}, {95'b0, tbl[i].x_err});
            chk($sformatf("tbl%0d xfer_cnt", i), {80'b0, XFER_CNT}, {80'b0, tbl[i].x_cnt});
        end

        // isolation: dest 2 held FULL while dest 0 streams
        hold2 = 32'hAAAA0002;
        drive(1'b0, 1'b1, 3'd2, hold2, 3'b011);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 3'd0, 32'hC0DE0000 + W'(i), 3'b011);
            chk($sformatf("iso%0d in_ready", i), {95'b0, IN_READY}, {95'b0, 1'b1});
            tick();
            chk($sformatf("iso%0d d0", i), {64'b0, OUT_DATA[0 +: W]}, {64'b0, 32'hC0DE0000 + W'(i)});
            chk($sformatf("iso%0d d2", i), {64'b0, OUT_DATA[2*W +: W]}, {64'b0, hold2});
            chk($sformatf("iso%0d ov", i), {93'b0, OUT_VALID}, {93'b0, 3'b101});
        end
        drive(1'b0, 1'b0, 3'd0, 32'h0, 3'b111);
        tick();
        chk("iso drained", {93'b0, OUT_VALID}, {93'b0, 3'b000});

        // counter wrap then reset with a held word
        drive(1'b1, 1'b0, 3'd0, 32'h0, 3'b111);
        tick();
        for (int i = 0; i < 65535; i++) begin
            drive(1'b0, 1'b1, 3'd0, W'(i), 3'b111);
            tick();
        end
        chk("cnt ffff", {80'b0, XFER_CNT}, {80'b0, 16'hFFFF});
        drive(1'b0, 1'b1, 3'd2, 32'h5, 3'b111);
        tick();
        chk("cnt wrap", {80'b0, XFER_CNT}, {80'b0, 16'h0000});
        drive(1'b0, 1'b1, 3'd1, 32'hBEEF0001, 3'b101);
        tick();
        chk("d1 full", {93'b0, OUT_VALID}, {93'b0, 3'b010});
        drive(1'b1, 1'b1, 3'd1, 32'hBEEF0002, 3'b000);
        tick();
        od0 = '0;
        chk("rst ov", {93'b0, OUT_VALID}, {93'b0, 3'b000});
        chk("rst od", OUT_DATA, od0);
        chk("rst cnt", {80'b0, XFER_CNT}, 96'b0);

        // randomized traffic against the model
        for (int k = 0; k < N; k++) begin mv[k] = 1'b0; md[k] = '0; end
        mcnt = 0; merr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            logic         r_rst, r_iv, x_rdy, a;
            logic [S-1:0] r_sel;
            logic [W-1:0] r_d;
            logic [N-1:0] r_ordy;
            int           r;
            r_rst  = ($urandom_range(0, 49) == 0);
            r_iv   = ($urandom_range(0, 3) != 0);
            r      = $urandom_range(0, 9);
            r_sel  = (r < 8) ? S'(r % N) : S'($urandom_range(N, 7));
            r_d    = $urandom;
            r_ordy = N'($urandom);
            drive(r_rst, r_iv, r_sel, r_d, r_ordy);
            x_rdy = (int'(r_sel) < N) ? (!mv[r_sel] || r_ordy[r_sel]) : 1'b1;
            chk($sformatf("rnd%0d in_ready", c), {95'b0, IN_READY}, {95'b0, x_rdy});
            if (r_rst) begin
                for (int k = 0; k < N; k++) begin mv[k] = 1'b0; md[k] = '0; end
                mcnt = 0; merr = 1'b0;
            end else begin
                a = r_iv && x_rdy;
                for (int k = 0; k < N; k++) begin
                    if (a && int'(r_sel) == k) begin mv[k] = 1'b1; md[k] = r_d; end
                    else if (mv[k] && r_ordy[k]) mv[k] = 1'b0;
                end
                merr = a && (int'(r_sel) >= N);
                if (a && int'(r_sel) < N) mcnt = (mcnt + 1) % 65536;
            end
            tick();
            chk($sformatf("rnd%0d ov", c), {93'b0, OUT_VALID}, {93'b0, model_ov()});
            chk($sformatf("rnd%0d od", c), OUT_DATA, model_od());
            chk($sformatf("rnd%0d err", c), {95'b0, SEL_ERR}, {95'b0, merr});
            chk($sformatf("rnd%0d cnt", c), {80'b0, XFER_CNT}, {80'b0, 16'(mcnt)});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
